// File: rtl/key_debounce_pkg.sv
// key_debounce_pkg.sv - definitions shared by the key debouncer files:
// channel FSM state encodings and the ms-to-cycles conversion.
package key_debounce_pkg;

  // Channel FSM states; encodings are fixed so they read the same in every file
  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    PRESS_WAIT   = 3'd1,
    PRESSED      = 3'd2,
    HELD         = 3'd3,
    RELEASE_WAIT = 3'd4
  } key_fsm_e;

  // Terminal count for a duration in ms: the count runs 0..N, so N+1 cycles
  function automatic int ms_to_cycles(input int clk_hz, input int ms);
    return clk_hz / 1000 * ms - 1;
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// key_debounce_ch.sv - one key channel: 2-flop synchroniser, debounce FSM
// with a single shared counter, registered level and pulse outputs.
// Build option: define KEY_REPEAT_EN to get auto-repeat press pulses while held.
module key_debounce_ch
  import key_debounce_pkg::*;
#(
  parameter int CLK_HZ      = 12_000_000,
  parameter int DEBOUNCE_MS = 20,
  parameter int LONG_MS     = 1000,
  parameter int REPEAT_MS   = 100
) (
  input  logic CLK,
  input  logic RST_n,
  input  logic key_n,
  output logic key_state,
  output logic key_press,
  output logic key_release,
  output logic key_long
);

  localparam int DB_CNT   = ms_to_cycles(CLK_HZ, DEBOUNCE_MS);
  localparam int LONG_CNT = ms_to_cycles(CLK_HZ, LONG_MS);
`ifdef KEY_REPEAT_EN
  localparam int RPT_CNT  = ms_to_cycles(CLK_HZ, REPEAT_MS);
  localparam int MAX_CNT  = max_int(max_int(DB_CNT, LONG_CNT), RPT_CNT);
`else
  localparam int MAX_CNT  = max_int(DB_CNT, LONG_CNT);
`endif
  // One spare bit keeps the saturation value above every terminal count
  localparam int CNT_W = $clog2(MAX_CNT + 1) + 1;

  localparam logic [CNT_W-1:0] DB_TC   = CNT_W'(DB_CNT);
  localparam logic [CNT_W-1:0] LONG_TC = CNT_W'(LONG_CNT);
`ifdef KEY_REPEAT_EN
  localparam logic [CNT_W-1:0] RPT_TC  = CNT_W'(RPT_CNT);
`endif
  localparam logic [CNT_W-1:0] CNT_SAT = '1;

  logic             sync1_reg, sync2_reg;
  logic             pressed_s;
  key_fsm_e         state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next, cnt_inc;
  logic             level_reg, level_next;
  logic             press_reg, press_next;
  logic             release_reg, release_next;
  logic             long_reg, long_next;
  logic             long_done_reg, long_done_next;

  // Two-flop synchroniser; reset to the released (high) pin level
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      sync1_reg <= 1'b1;
      sync2_reg <= 1'b1;
    end else begin
      sync1_reg <= key_n;
      sync2_reg <= sync1_reg;
    end
  end

  assign pressed_s = ~sync2_reg;
  assign cnt_inc   = (cnt_reg == CNT_SAT) ? cnt_reg : cnt_reg + 1'b1;

  // FSM state, counter and registered outputs
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      level_reg     <= 1'b0;
      press_reg     <= 1'b0;
      release_reg   <= 1'b0;
      long_reg      <= 1'b0;
      long_done_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      level_reg     <= level_next;
      press_reg     <= press_next;
      release_reg   <= release_next;
      long_reg      <= long_next;
      long_done_reg <= long_done_next;
    end
  end

  // Next-state logic; pulse requests default low so each lasts one cycle
  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    level_next     = level_reg;
    press_next     = 1'b0;
    release_next   = 1'b0;
    long_next      = 1'b0;
    long_done_next = long_done_reg;
    case (state_reg)
      IDLE: begin
        if (pressed_s) begin
          state_next = PRESS_WAIT;
          cnt_next   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!pressed_s) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else if (cnt_reg == DB_TC) begin
          state_next     = PRESSED;
          cnt_next       = '0;
          level_next     = 1'b1;
          press_next     = 1'b1;
          long_done_next = 1'b0;
        end else begin
          cnt_next = cnt_inc;
        end
      end
      PRESSED: begin
        if (!pressed_s) begin
          state_next = RELEASE_WAIT;
          cnt_next   = '0;
        end else if (cnt_reg == LONG_TC) begin
          state_next     = HELD;
          cnt_next       = '0;
          long_next      = 1'b1;
          long_done_next = 1'b1;
        end else begin
          cnt_next = cnt_inc;
        end
      end
      HELD: begin
        if (!pressed_s) begin
          state_next = RELEASE_WAIT;
          cnt_next   = '0;
        end
`ifdef KEY_REPEAT_EN
        else if (cnt_reg == RPT_TC) begin
          cnt_next   = '0;
          press_next = 1'b1;
        end else begin
          cnt_next = cnt_inc;
        end
`endif
      end
      RELEASE_WAIT: begin
        if (pressed_s) begin
          // Bounce during release: resume the hold without re-arming key_long
          state_next = long_done_reg ? HELD : PRESSED;
          cnt_next   = '0;
        end else if (cnt_reg == DB_TC) begin
          state_next     = IDLE;
          cnt_next       = '0;
          level_next     = 1'b0;
          release_next   = 1'b1;
          long_done_next = 1'b0;
        end else begin
          cnt_next = cnt_inc;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  assign key_state   = level_reg;
  assign key_press   = press_reg;
  assign key_release = release_reg;
  assign key_long    = long_reg;

endmodule

// File: rtl/key_debounce.sv
// key_debounce.sv - NUM_KEYS independent debounced push-button channels.
// Build option: define KEY_REPEAT_EN to get auto-repeat press pulses while held.
module key_debounce
  import key_debounce_pkg::*;
#(
  parameter int NUM_KEYS    = 4,
  parameter int CLK_HZ      = 12_000_000,
  parameter int DEBOUNCE_MS = 20,
  parameter int LONG_MS     = 1000,
  parameter int REPEAT_MS   = 100
) (
  input  logic                CLK,
  input  logic                RST_n,
  input  logic [NUM_KEYS-1:0] KEY_n,
  output logic [NUM_KEYS-1:0] key_state,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic [NUM_KEYS-1:0] key_long
);

  // One self-contained channel per key; no state is shared between keys
  generate
    for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_ch
      key_debounce_ch #(
        .CLK_HZ      (CLK_HZ),
        .DEBOUNCE_MS (DEBOUNCE_MS),
        .LONG_MS     (LONG_MS),
        .REPEAT_MS   (REPEAT_MS)
      ) u_ch (
        .CLK         (CLK),
        .RST_n       (RST_n),
        .key_n       (KEY_n[gi]),
        .key_state   (key_state[gi]),
        .key_press   (key_press[gi]),
        .key_release (key_release[gi]),
        .key_long    (key_long[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_key_debounce.sv
// tb_key_debounce.sv - self-checking bench for key_debounce with shortened
// timing (DB_CNT=19, LONG_CNT=99, RPT_CNT=29). Honours KEY_REPEAT_EN.
module tb_key_debounce;

  localparam int NK   = 4;
  localparam int DB   = 19;
  localparam int LONG = 99;
  localparam int RPT  = 29;
  // From a pin change (driven at a negedge) to the pulse, counted in rising edges
  localparam int LAT  = DB + 4;

  logic          CLK = 1'b0;
  logic          RST_n = 1'b0;
  logic [NK-1:0] KEY_n = '1;
  logic [NK-1:0] key_state, key_press, key_release, key_long;

  key_debounce #(
    .NUM_KEYS(NK), .CLK_HZ(10_000), .DEBOUNCE_MS(2), .LONG_MS(10), .REPEAT_MS(3)
  ) dut (
    .CLK(CLK), .RST_n(RST_n), .KEY_n(KEY_n),
    .key_state(key_state), .key_press(key_press),
    .key_release(key_release), .key_long(key_long)
  );

  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;
  int n_press = 0, n_release = 0, n_long = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      if (errors <= 30)
        $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Press accepted after DB+2 consecutive pressed samples, release after DB+2
  // released samples; long fires LONG+1 pressed cycles after the press or
  // after the last release-bounce; repeats every RPT+1 cycles after that.
  logic [NK-1:0] m_sync1, m_sync2;
  int            run1[NK], run0[NK];
  bit            lvl[NK], fired[NK];
  longint        now = 0;
  longint        t_press[NK], t_zero[NK], t_rep[NK];
  logic [NK-1:0] e_state, e_press, e_release, e_long;

  function automatic longint lmax(input longint a, input longint b);
    return (a > b) ? a : b;
  endfunction

  task automatic model_reset();
    m_sync1 = '1; m_sync2 = '1;
    e_state = '0; e_press = '0; e_release = '0; e_long = '0;
    for (int i = 0; i < NK; i++) begin
      run1[i] = 0; run0[i] = 0; lvl[i] = 0; fired[i] = 0;
      t_press[i] = -1000000; t_zero[i] = -1000000; t_rep[i] = -1000000;
    end
  endtask

  task automatic model_step(input logic [NK-1:0] kn, input logic rn);
    logic [NK-1:0] s;
    now++;
    if (!rn) begin
      model_reset();
      return;
    end
    e_press = '0; e_release = '0; e_long = '0;
    s = ~m_sync2;
    for (int i = 0; i < NK; i++) begin
      if (s[i]) begin run1[i]++; run0[i] = 0; end
      else      begin run0[i]++; run1[i] = 0; end
      if (!lvl[i]) begin
        if (run1[i] == DB + 2) begin
          lvl[i] = 1; fired[i] = 0; t_press[i] = now; e_press[i] = 1'b1;
        end
      end else begin
        if (!s[i]) t_zero[i] = now;
        if (run0[i] == DB + 2) begin
          lvl[i] = 0; e_release[i] = 1'b1;
        end else if (s[i] && !fired[i] &&
                     now - lmax(t_press[i], t_zero[i] + 1) == LONG + 1) begin
          fired[i] = 1; t_rep[i] = now; e_long[i] = 1'b1;
        end
`ifdef KEY_REPEAT_EN
        else if (s[i] && fired[i] &&
                 now - lmax(t_rep[i], t_zero[i] + 1) == RPT + 1) begin
          t_rep[i] = now; e_press[i] = 1'b1;
        end
`endif
      end
      e_state[i] = lvl[i];
    end
    m_sync2 = m_sync1;
    m_sync1 = kn;
  endtask

  // Cycle-by-cycle comparison against the model, plus pulse tallies
  initial begin
    model_reset();
    forever begin
      @(posedge CLK);
      model_step(KEY_n, RST_n);
      #1;
      chk("model_state",   key_state,   e_state);
      chk("model_press",   key_press,   e_press);
      chk("model_release", key_release, e_release);
      chk("model_long",    key_long,    e_long);
      chk("press_release_overlap", key_press & key_release, 0);
      n_press   += $countones(key_press);
      n_release += $countones(key_release);
      n_long    += $countones(key_long);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive(input logic [NK-1:0] kn);
    @(negedge CLK);
    KEY_n = kn;
  endtask

  task automatic hold(input logic [NK-1:0] kn, input int cycles);
    @(negedge CLK);
    KEY_n = kn;
    repeat (cycles) @(posedge CLK);
    #2;
  endtask

  // kind: 0 press, 1 release, 2 long; n = edge index of the pulse or -1
  task automatic wait_for(input int key, input int kind, input int limit, output int n);
    logic [NK-1:0] v;
    n = -1;
    for (int c = 1; c <= limit; c++) begin
      @(posedge CLK);
      #2;
      v = (kind == 0) ? key_press : (kind == 1) ? key_release : key_long;
      if (v[key]) begin
        n = c;
        break;
      end
    end
  endtask

  task automatic clear_tallies();
    n_press = 0; n_release = 0; n_long = 0;
  endtask

  typedef struct {
    logic [NK-1:0] key_n;
    int            cycles;
    logic [NK-1:0] exp_state;
    int            exp_press;
    int            exp_release;
    int            exp_long;
  } vec_t;

  vec_t vecs[9];
  int   n;
  int   exp_rep_lat;
  int   exp_rep_cnt;
  int   left[NK];

  initial begin
`ifdef KEY_REPEAT_EN
    exp_rep_lat = RPT + 1;
    exp_rep_cnt = 3;
`else
    exp_rep_lat = -1;
    exp_rep_cnt = 0;
`endif
    vecs[0] = '{4'b1111, 30,  4'b0000, 0, 0, 0};
    vecs[1] = '{4'b1110, 200, 4'b0001, 1 + exp_rep_cnt - 1, 0, 1};
    vecs[2] = '{4'b1111, 40,  4'b0000, 0, 1, 0};
    vecs[3] = '{4'b0110, 60,  4'b1001, 2, 0, 0};
    vecs[4] = '{4'b1111, 40,  4'b0000, 0, 2, 0};
    vecs[5] = '{4'b1101, 10,  4'b0000, 0, 0, 0};
    vecs[6] = '{4'b1111, 30,  4'b0000, 0, 0, 0};
    vecs[7] = '{4'b0000, 30,  4'b1111, 4, 0, 0};
    vecs[8] = '{4'b1111, 30,  4'b0000, 0, 4, 0};
`ifndef KEY_REPEAT_EN
    vecs[1].exp_press = 1;
`endif

    // Reset
    repeat (5) @(posedge CLK);
    #2;
    chk("reset_outputs", {key_state, key_press, key_release, key_long}, 0);
    @(negedge CLK);
    RST_n = 1'b1;
    repeat (5) @(posedge CLK);

    // Table-driven phases
    for (int v = 0; v < 9; v++) begin
      clear_tallies();
      hold(vecs[v].key_n, vecs[v].cycles);
      $display("vec %0d key_n=%b state=%b presses=%0d releases=%0d longs=%0d",
               v, vecs[v].key_n, key_state, n_press, n_release, n_long);
      chk($sformatf("vec%0d_state", v),    key_state, vecs[v].exp_state);
      chk($sformatf("vec%0d_press", v),    n_press,   vecs[v].exp_press);
      chk($sformatf("vec%0d_release", v),  n_release, vecs[v].exp_release);
      chk($sformatf("vec%0d_long", v),     n_long,    vecs[v].exp_long);
    end

    // Clean press of key 0: latency, long press, repeat, release
    drive(4'b1110);
    wait_for(0, 0, 60, n);
    chk("press0_latency", n, LAT);
    chk("press0_state", key_state, 4'b0001);
    wait_for(0, 2, 150, n);
    chk("long0_after_press", n, LONG + 1);
    wait_for(0, 0, 60, n);
    chk("repeat0_after_long", n, exp_rep_lat);
    drive(4'b1111);
    wait_for(0, 1, 60, n);
    chk("release0_latency", n, LAT);
    chk("release0_state", key_state, 4'b0000);
    $display("seq clean_press key0 done");

    // Bounce on key 1
    clear_tallies();
    hold(4'b1101, 10);
    hold(4'b1111, 3);
    chk("bounce1_no_press", n_press, 0);
    drive(4'b1101);
    wait_for(1, 0, 60, n);
    chk("bounce1_press_latency", n, LAT);
    hold(4'b1101, 20);
    drive(4'b1111);
    wait_for(1, 1, 60, n);
    chk("bounce1_release", n, LAT);
    $display("seq bounce key1 done");

    // 50-cycle hold on key 2, then release: no long press
    clear_tallies();
    hold(4'b1011, 50);
    chk("hold2_press_count", n_press, 1);
    drive(4'b1111);
    wait_for(2, 1, 60, n);
    chk("release2_latency", n, LAT);
    chk("release2_state", key_state[2], 0);
    chk("hold2_no_long", n_long, 0);
    $display("seq short_hold key2 done");

    // Keys 0 and 3 together
    drive(4'b0110);
    wait_for(0, 0, 60, n);
    chk("simul_latency", n, LAT);
    chk("simul_press_vec", key_press, 4'b1001);
    drive(4'b1111);
    wait_for(0, 1, 60, n);
    chk("simul_release_vec", key_release, 4'b1001);
    $display("seq simultaneous keys0,3 done");

    // Reset during PRESS_WAIT with key held through reset
    drive(4'b1110);
    repeat (10) @(posedge CLK);
    @(negedge CLK);
    RST_n = 1'b0;
    #1;
    chk("rst_pw_outputs", {key_state, key_press, key_release, key_long}, 0);
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    RST_n = 1'b1;
    wait_for(0, 0, 60, n);
    chk("rst_pw_press_latency", n, LAT);

    // Reset while PRESSED
    repeat (30) @(posedge CLK);
    @(negedge CLK);
    RST_n = 1'b0;
    #1;
    chk("rst_pressed_outputs", {key_state, key_press, key_release, key_long}, 0);
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    RST_n = 1'b1;
    wait_for(0, 0, 60, n);
    chk("rst_pressed_press_latency", n, LAT);
    $display("seq reset_mid_press done");

    // 200-cycle hold after the press: one long, repeats only when enabled
    clear_tallies();
    repeat (200) @(posedge CLK);
    #2;
    chk("hold200_long_count", n_long, 1);
    chk("hold200_repeat_count", n_press, exp_rep_cnt);
    hold(4'b1111, 40);
    $display("seq long_hold key0 done");

    // Randomised pin activity against the model
    for (int i = 0; i < NK; i++) left[i] = 1;
    for (int c = 0; c < 3000; c++) begin
      @(negedge CLK);
      for (int i = 0; i < NK; i++) begin
        left[i]--;
        if (left[i] == 0) begin
          KEY_n[i] = ~KEY_n[i];
          left[i] = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 8))
                                                : int'($urandom_range(20, 160));
        end
      end
      if (c == 1500) RST_n = 1'b0;
      if (c == 1503) RST_n = 1'b1;
    end
    hold(4'b1111, 40);
    $display("seq random done");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
